// File: rtl/merc16_pkg.sv
// MERC-16 shared definitions: control-field encodings driven by the external
// controller and the architectural register indices.
package merc16_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_NOT = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_CMP = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    RD_MDR    = 2'd0,
    RD_ALUOUT = 2'd1,
    RD_PC     = 2'd2,
    RD_IMM    = 2'd3
  } reg_data_t;

  typedef enum logic [1:0] {
    DST_IR     = 2'd0,
    DST_IR_ALT = 2'd1,
    DST_RA     = 2'd2,
    DST_SP     = 2'd3
  } reg_dest_t;

  typedef enum logic [1:0] {
    RS_IR_RS = 2'd0,
    RS_IR_RD = 2'd1,
    RS_RA    = 2'd2,
    RS_SP    = 2'd3
  } rs_rd_t;

  typedef enum logic [1:0] {
    SRCB_B    = 2'd0,
    SRCB_ONE  = 2'd1,
    SRCB_SE4  = 2'd2,
    SRCB_IMM8 = 2'd3
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PC_JUMP   = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_ALU    = 2'd2,
    PC_A      = 2'd3
  } pc_src_t;

  localparam logic [3:0] REG_ZERO = 4'd0;
  localparam logic [3:0] REG_RA   = 4'd1;
  localparam logic [3:0] REG_T0   = 4'd2;
  localparam logic [3:0] REG_T1   = 4'd3;
  localparam logic [3:0] REG_T2   = 4'd4;
  localparam logic [3:0] REG_SP   = 4'd5;

endpackage

// File: rtl/merc16_alu.sv
// MERC-16 ALU: 16-bit wraparound arithmetic/logic unit.
//   op     : operation (alu_op_t)
//   a, b   : operands (a = SrcA, b = SrcB)
//   result : operation result
//   Zero   : result == 0
//   Ovfl   : signed overflow for add/sub/cmp, 0 otherwise
module merc16_alu
  import merc16_pkg::*;
(
  input  alu_op_t     op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        Zero,
  output logic        Ovfl
);

  always_comb begin
    result = '0;
    Ovfl   = 1'b0;
    case (op)
      ALU_ADD: begin
        result = a + b;
        // operands share a sign that the result does not
        Ovfl   = ~(a[15] ^ b[15]) & (result[15] ^ a[15]);
      end
      ALU_SUB, ALU_CMP: begin
        result = a - b;
        Ovfl   = (a[15] ^ b[15]) & (result[15] ^ a[15]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOT: result = ~a;
      ALU_SLL: result = a << b[3:0];
      ALU_SRL: result = a >> b[3:0];
      default: result = '0;
    endcase
  end

  assign Zero = (result == '0);

endmodule

// File: rtl/pc_memory_decode_alu_subsystem.sv
// MERC-16 multicycle datapath: PC, unified instruction/data memory, IR, MDR,
// 16x16 register file, A/B operand registers, ALU and ALUOut. Every select and
// write enable comes from an external controller each cycle.
//   Clock, Reset (sync, active low)
//   WritePC, InstData, WriteMemory, WriteIR, RegData, RegDest, WriteRegister,
//   RsRd, RsRt, ZE_SE, ALU_SrcA, ALU_SrcB, UpperLower, ALU_Op, PC_Src : controls
//   EQ/GR/LT : signed compare of A vs B;  Zero/Ovfl : ALU status
// Memory starts all zeros. Reset never touches memory.
module pc_memory_decode_alu_subsystem
  import merc16_pkg::*;
#(
  parameter int unsigned MEM_DEPTH     = 4096,
  parameter              MEM_INIT_FILE = "mem.hex"
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       WritePC,
  input  logic       InstData,
  input  logic       WriteMemory,
  input  logic       WriteIR,
  input  logic [1:0] RegData,
  input  logic [1:0] RegDest,
  input  logic       WriteRegister,
  input  logic [1:0] RsRd,
  input  logic       RsRt,
  input  logic       ZE_SE,
  input  logic       ALU_SrcA,
  input  logic [1:0] ALU_SrcB,
  input  logic       UpperLower,
  input  logic [2:0] ALU_Op,
  input  logic [1:0] PC_Src,
  output logic       EQ,
  output logic       GR,
  output logic       LT,
  output logic       Zero,
  output logic       Ovfl
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [15:0] pc, ir, mdr, a_reg, b_reg, alu_out;
  logic [15:0] rf [16];

  logic [15:0] mem [MEM_DEPTH] = '{default: '0};
  localparam unused_init_file = MEM_INIT_FILE;

  logic [15:0] mem_addr, mem_rdata;
  logic [AW-1:0] mem_index;
  logic [15:0] unused_addr;
  logic [3:0]  unused_opcode;
  logic [3:0]  wr_sel, a_sel, b_sel;
  logic [15:0] wr_data, a_rdata, b_rdata, imm8, src_a, src_b, alu_result, pc_next;

  // Only the low AW address bits select a word; the opcode nibble is decoded by the controller.
  assign mem_addr      = InstData ? alu_out : pc;
  assign mem_index     = mem_addr[AW-1:0];
  assign mem_rdata     = mem[mem_index];
  assign unused_addr   = mem_addr;
  assign unused_opcode = ir[15:12];

  always_comb begin
    wr_sel  = ir[11:8];
    a_sel   = ir[7:4];
    wr_data = mdr;
    src_b   = b_reg;
    pc_next = {pc[15:12], ir[11:0]};
    case (reg_dest_t'(RegDest))
      DST_RA:  wr_sel = REG_RA;
      DST_SP:  wr_sel = REG_SP;
      default: wr_sel = ir[11:8];
    endcase
    case (rs_rd_t'(RsRd))
      RS_IR_RD: a_sel = ir[11:8];
      RS_RA:    a_sel = REG_RA;
      RS_SP:    a_sel = REG_SP;
      default:  a_sel = ir[7:4];
    endcase
    case (reg_data_t'(RegData))
      RD_ALUOUT: wr_data = alu_out;
      RD_PC:     wr_data = pc;
      RD_IMM:    wr_data = UpperLower ? {ir[7:0], 8'h00} : {8'h00, ir[7:0]};
      default:   wr_data = mdr;
    endcase
    case (alu_src_b_t'(ALU_SrcB))
      SRCB_ONE:  src_b = 16'd1;
      SRCB_SE4:  src_b = {{12{ir[3]}}, ir[3:0]};
      SRCB_IMM8: src_b = imm8;
      default:   src_b = b_reg;
    endcase
    case (pc_src_t'(PC_Src))
      PC_ALUOUT: pc_next = alu_out;
      PC_ALU:    pc_next = alu_result;
      PC_A:      pc_next = a_reg;
      default:   pc_next = {pc[15:12], ir[11:0]};
    endcase
  end

  assign b_sel   = RsRt ? ir[3:0] : ir[11:8];
  assign a_rdata = (a_sel == REG_ZERO) ? '0 : rf[a_sel];
  assign b_rdata = (b_sel == REG_ZERO) ? '0 : rf[b_sel];
  assign imm8    = ZE_SE ? {{8{ir[7]}}, ir[7:0]} : {8'h00, ir[7:0]};
  assign src_a   = ALU_SrcA ? a_reg : pc;

  merc16_alu u_alu (
    .op     (alu_op_t'(ALU_Op)),
    .a      (src_a),
    .b      (src_b),
    .result (alu_result),
    .Zero   (Zero),
    .Ovfl   (Ovfl)
  );

  assign EQ = (a_reg == b_reg);
  assign GR = ($signed(a_reg) > $signed(b_reg));
  assign LT = ($signed(a_reg) < $signed(b_reg));

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc      <= '0;
      ir      <= '0;
      mdr     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      for (int unsigned i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      a_reg   <= a_rdata;
      b_reg   <= b_rdata;
      alu_out <= alu_result;
      mdr     <= mem_rdata;
      if (WritePC) pc <= pc_next;
      if (WriteIR) ir <= mem_rdata;
      if (WriteRegister && (wr_sel != REG_ZERO)) rf[wr_sel] <= wr_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (WriteMemory) mem[mem_index] <= b_reg;
  end

endmodule

// File: tb/tb_pc_memory_decode_alu_subsystem.sv
module tb_pc_memory_decode_alu_subsystem;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       WritePC, InstData, WriteMemory, WriteIR, WriteRegister;
  logic [1:0] RegData, RegDest, RsRd, ALU_SrcB, PC_Src;
  logic       RsRt, ZE_SE, ALU_SrcA, UpperLower;
  logic [2:0] ALU_Op;
  logic       EQ, GR, LT, Zero, Ovfl;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] exp_rf [16];
  logic [15:0] exp_pc;

  pc_memory_decode_alu_subsystem #(.MEM_DEPTH(4096)) dut (
    .Clock(Clock), .Reset(Reset), .WritePC(WritePC), .InstData(InstData),
    .WriteMemory(WriteMemory), .WriteIR(WriteIR), .RegData(RegData), .RegDest(RegDest),
    .WriteRegister(WriteRegister), .RsRd(RsRd), .RsRt(RsRt), .ZE_SE(ZE_SE),
    .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .UpperLower(UpperLower), .ALU_Op(ALU_Op),
    .PC_Src(PC_Src), .EQ(EQ), .GR(GR), .LT(LT), .Zero(Zero), .Ovfl(Ovfl)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    WritePC = 0; InstData = 0; WriteMemory = 0; WriteIR = 0; WriteRegister = 0;
    RegData = 0; RegDest = 0; RsRd = 0; RsRt = 0; ZE_SE = 0; ALU_SrcA = 0;
    ALU_SrcB = 0; UpperLower = 0; ALU_Op = 0; PC_Src = 0;
  endtask

  function automatic int to_s(input logic [15:0] v);
    return (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
  endfunction

  // Reference ALU from plain integer arithmetic.
  function automatic void ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] res, output logic ovf);
    int     full;
    longint scale;
    logic [3:0] sh;
    sh    = b[3:0];
    scale = longint'(1) << sh;
    ovf   = 1'b0;
    case (op)
      3'd0: begin full = to_s(a) + to_s(b); res = 16'(full); ovf = (full > 32767) || (full < -32768); end
      3'd1, 3'd7: begin full = to_s(a) - to_s(b); res = 16'(full); ovf = (full > 32767) || (full < -32768); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = 16'hFFFF - a;
      3'd5: res = 16'(longint'(a) * scale);
      default: res = 16'(longint'(a) / scale);
    endcase
  endfunction

  task automatic poke(input logic [11:0] addr, input logic [15:0] val);
    dut.mem[addr] = val;
  endtask

  task automatic load_ir(input logic [15:0] val);
    poke(exp_pc[11:0], val);
    WriteIR = 1;
    tick();
    WriteIR = 0;
  endtask

  // Instruction word names rd, then the data word at PC reaches MDR and is written.
  task automatic load_reg(input logic [3:0] rd, input logic [15:0] val);
    load_ir({4'h0, rd, 8'h00});
    poke(exp_pc[11:0], val);
    tick();
    RegData = 0; RegDest = 0; WriteRegister = 1;
    tick();
    idle();
    if (rd != 0) exp_rf[rd] = val;
  endtask

  task automatic alu_run(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [2:0] op);
    logic [15:0] a, b, res;
    logic        ovf;
    load_ir({4'h0, rd, rs, rt});
    RsRd = 0; RsRt = 1; ALU_SrcA = 1; ALU_SrcB = 0; ALU_Op = op;
    tick();
    a = exp_rf[rs];
    b = exp_rf[rt];
    ref_alu(op, a, b, res, ovf);
    chk("eq", EQ, a == b);
    chk("gr", GR, to_s(a) > to_s(b));
    chk("lt", LT, to_s(a) < to_s(b));
    chk("zero", Zero, res == 16'h0);
    chk("ovfl", Ovfl, ovf);
    tick();
    chk("alu_out", dut.alu_out, res);
    RegData = 1; RegDest = 0; WriteRegister = 1;
    tick();
    WriteRegister = 0;
    if (rd != 0) exp_rf[rd] = res;
    chk("rf_write", dut.rf[rd], exp_rf[rd]);
  endtask

  initial begin
    logic [3:0]  rs, rt, rd;
    logic [15:0] va, vb;
    logic [2:0]  op;

    idle();
    Reset = 0;
    for (int i = 0; i < 16; i++) exp_rf[i] = '0;
    exp_pc = '0;
    tick();
    Reset = 1;
    chk("rst_pc", dut.pc, 16'h0);
    chk("rst_ir", dut.ir, 16'h0);
    chk("rst_a", dut.a_reg, 16'h0);
    chk("rst_b", dut.b_reg, 16'h0);
    chk("rst_eq", EQ, 1'b1);
    chk("rst_gr", GR, 1'b0);
    chk("rst_lt", LT, 1'b0);

    // load-immediate into IR[11:8] (r2)
    load_ir(16'h1205);
    chk("ir_fetch", dut.ir, 16'h1205);
    RegData = 3; RegDest = 1; UpperLower = 0; WriteRegister = 1;
    tick();
    chk("li_low", dut.rf[2], 16'h0005);
    UpperLower = 1;
    tick();
    chk("li_high", dut.rf[2], 16'h0500);
    idle();
    exp_rf[2] = 16'h0500;

    // PC + 1 through ALUOut, then jump
    ALU_SrcA = 0; ALU_SrcB = 1; ALU_Op = 0;
    tick();
    PC_Src = 1; WritePC = 1;
    tick();
    idle();
    exp_pc = 16'h0001;
    chk("pc_inc", dut.pc, exp_pc);
    load_ir(16'hF123);
    PC_Src = 0; WritePC = 1;
    tick();
    idle();
    exp_pc = 16'h0123;
    chk("pc_jump", dut.pc, exp_pc);

    // arithmetic through A/B
    load_reg(4'd3, 16'd7);
    load_reg(4'd4, 16'd9);
    alu_run(4'd5, 4'd3, 4'd4, 3'd0);
    chk("add_r5", dut.rf[5], 16'd16);
    alu_run(4'd5, 4'd3, 4'd4, 3'd1);
    chk("sub_r5", dut.rf[5], 16'hFFFE);
    chk("sub_lt", LT, 1'b1);
    idle();
    load_reg(4'd3, 16'h7FFF);
    load_ir(16'h0530);
    RsRd = 0; ALU_SrcA = 1; ALU_SrcB = 1; ALU_Op = 0;
    tick();
    chk("ovfl_add", Ovfl, 1'b1);
    tick();
    chk("ovfl_res", dut.alu_out, 16'h8000);
    idle();

    // store B at ALUOut, read back through MDR
    load_reg(4'd6, 16'hBEEF);
    load_reg(4'd7, 16'h0040);
    load_ir(16'h0670);
    RsRd = 0; RsRt = 0; ALU_SrcA = 1; ALU_SrcB = 2; ALU_Op = 0;
    tick();
    tick();
    chk("st_addr", dut.alu_out, 16'h0040);
    InstData = 1; WriteMemory = 1;
    tick();
    chk("st_mem", dut.mem[64], 16'hBEEF);
    WriteMemory = 0;
    tick();
    chk("ld_mdr", dut.mdr, 16'hBEEF);
    RegData = 0; RegDest = 3; WriteRegister = 1;
    tick();
    idle();
    exp_rf[5] = 16'hBEEF;
    chk("ld_r5", dut.rf[5], 16'hBEEF);

    // call: old PC saved in r1 on the same edge the PC jumps
    load_ir(16'hF010);
    PC_Src = 0; WritePC = 1;
    tick();
    idle();
    exp_pc = 16'h0010;
    chk("pc_pre_call", dut.pc, exp_pc);
    load_ir(16'hF200);
    PC_Src = 0; WritePC = 1; RegData = 2; RegDest = 2; WriteRegister = 1;
    tick();
    idle();
    exp_rf[1] = exp_pc;
    exp_pc = 16'h0200;
    chk("call_pc", dut.pc, exp_pc);
    chk("call_ra", dut.rf[1], 16'h0010);

    // writes to r0 are dropped
    load_ir(16'h00AB);
    RegData = 3; RegDest = 0; WriteRegister = 1;
    tick();
    WriteRegister = 0; RsRd = 1;
    tick();
    chk("r0_zero", dut.a_reg, 16'h0000);
    idle();

    // read during write returns the old register value
    RsRd = 3; RegData = 2; RegDest = 3; WriteRegister = 1;
    tick();
    chk("rw_old", dut.a_reg, exp_rf[5]);
    exp_rf[5] = exp_pc;
    WriteRegister = 0;
    tick();
    chk("rw_new", dut.a_reg, exp_rf[5]);
    idle();

    // randomized ALU operations against the reference model
    for (int it = 0; it < 40; it++) begin
      rs = 4'($urandom_range(2, 15));
      rt = 4'($urandom_range(2, 15));
      rd = 4'($urandom_range(1, 15));
      op = 3'($urandom_range(0, 7));
      va = 16'($urandom);
      vb = 16'($urandom);
      if (it % 8 == 0) va = 16'h7FFF;
      if (it % 8 == 1) va = 16'h8000;
      if (it % 8 == 2) vb = va;
      load_reg(rs, va);
      load_reg(rt, vb);
      alu_run(rd, rs, rt, op);
      idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
